// File: rtl/imem_loader.sv
// Instruction memory write side: streams bytes from a valid/ready source into
// consecutive addresses starting at a programmable base, and serves the fetch
// stage a combinational big-endian window of WIN_BYTES bytes starting at rd_addr.
module imem_loader #(
   parameter int MEM_BYTES = 256,
   parameter int WIN_BYTES = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ld_start,
   input  logic [7:0]             ld_base,
   input  logic [8:0]             ld_len,
   input  logic                   s_valid,
   input  logic [7:0]             s_data,
   output logic                   s_ready,
   input  logic [63:0]            rd_addr,
   output logic [WIN_BYTES*8-1:0] rd_instr,
   output logic                   rd_mem_error,
   output logic                   cpu_hold,
   output logic                   ld_done,
   output logic                   ld_err,
   output logic [8:0]             ld_count,
   output logic [7:0]             ld_csum
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] mem [MEM_BYTES];
   logic [7:0] base_q;
   logic [8:0] len_q;
   logic       start_ok;
   logic       accept;
   logic       start_take;

   // A load must be non-empty and end at or before the top of memory, so the
   // write address base_q + ld_count never wraps inside a load.
   assign start_ok   = (ld_len != 9'd0) &&
                       (({2'b00, ld_base} + {1'b0, ld_len}) <= 10'(MEM_BYTES));
   assign start_take = ld_start && (state != LOAD);
   assign accept     = s_valid && s_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: start is honoured everywhere except mid-load
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD: begin
            if (s_valid && (ld_count == len_q - 9'd1)) state_nxt = DONE;
         end
         default: begin
            if (ld_start) state_nxt = start_ok ? LOAD : ERR;
         end
      endcase
   end

   // Outputs decoded directly from state
   always_comb begin
      s_ready  = (state == LOAD);
      cpu_hold = (state == LOAD);
      ld_done  = (state == DONE);
      ld_err   = (state == ERR);
   end

   // Load bookkeeping and memory writes; reset also clears memory to halt bytes
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q   <= 8'h00;
         len_q    <= 9'd0;
         ld_count <= 9'd0;
         ld_csum  <= 8'h00;
         for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
      end else if (start_take && start_ok) begin
         base_q   <= ld_base;
         len_q    <= ld_len;
         ld_count <= 9'd0;
         ld_csum  <= 8'h00;
      end else if (accept) begin
         mem[base_q + ld_count[7:0]] <= s_data;
         ld_count <= ld_count + 9'd1;
         ld_csum  <= ld_csum + s_data;
      end
   end

   assign rd_mem_error = (rd_addr > 64'(MEM_BYTES - WIN_BYTES));

   // Fetch window: byte at rd_addr lands in the MSB; bytes past the top read 0
   always_comb begin
      rd_instr = '0;
      for (int i = 0; i < WIN_BYTES; i++) begin
         if ((rd_addr[63:8] == 56'd0) &&
             (({1'b0, rd_addr[7:0]} + 9'(i)) < 9'(MEM_BYTES)))
            rd_instr[(WIN_BYTES-1-i)*8 +: 8] = mem[rd_addr[7:0] + 8'(i)];
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed scenarios plus a randomized phase, every
// cycle compared against a byte-array reference model of the loader.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_start = 1'b0;
   logic [7:0]  ld_base = 8'h00;
   logic [8:0]  ld_len = 9'd0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_ready;
   logic [63:0] rd_addr = 64'd0;
   logic [79:0] rd_instr;
   logic        rd_mem_error;
   logic        cpu_hold;
   logic        ld_done;
   logic        ld_err;
   logic [8:0]  ld_count;
   logic [7:0]  ld_csum;

   int errors = 0;
   int checks = 0;

   // reference model
   logic [7:0] m_mem [256];
   bit         m_load, m_done, m_err;
   int         m_base, m_len, m_cnt, m_sum;

   logic [7:0] prog [20] = '{8'h30, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A,
                             8'h30, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};

   imem_loader dut (
      .clk(clk), .rst(rst), .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .rd_addr(rd_addr),
      .rd_instr(rd_instr), .rd_mem_error(rd_mem_error), .cpu_hold(cpu_hold),
      .ld_done(ld_done), .ld_err(ld_err), .ld_count(ld_count), .ld_csum(ld_csum)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [79:0] win(input logic [63:0] a);
      logic [79:0] r;
      logic [64:0] p;
      r = '0;
      for (int i = 0; i < 10; i++) begin
         p = {1'b0, a} + 65'(i);
         if (p < 65'd256) r[79-8*i -: 8] = m_mem[p[7:0]];
      end
      return r;
   endfunction

   // Apply the loader rules to the inputs present before the coming edge
   task automatic model_step();
      if (rst) begin
         foreach (m_mem[i]) m_mem[i] = 8'h00;
         m_load = 0; m_done = 0; m_err = 0; m_cnt = 0; m_sum = 0;
      end else if (m_load) begin
         if (s_valid) begin
            m_mem[m_base + m_cnt] = s_data;
            m_cnt++;
            m_sum = (m_sum + s_data) % 256;
            if (m_cnt == m_len) begin m_load = 0; m_done = 1; end
         end
      end else if (ld_start) begin
         if (ld_len == 0 || int'(ld_base) + int'(ld_len) > 256) begin
            m_err = 1; m_done = 0;
         end else begin
            m_load = 1; m_base = ld_base; m_len = ld_len;
            m_cnt = 0; m_sum = 0; m_done = 0; m_err = 0;
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check("s_ready", 80'(s_ready), 80'(m_load));
      check("cpu_hold", 80'(cpu_hold), 80'(m_load));
      check("ld_done", 80'(ld_done), 80'(m_done));
      check("ld_err", 80'(ld_err), 80'(m_err));
      check("ld_count", 80'(ld_count), 80'(m_cnt));
      check("ld_csum", 80'(ld_csum), 80'(m_sum));
      check("rd_instr", rd_instr, win(rd_addr));
      check("rd_mem_error", 80'(rd_mem_error), 80'(rd_addr > 64'd246));
   endtask

   task automatic start(input logic [7:0] b, input logic [8:0] n);
      ld_start = 1'b1; ld_base = b; ld_len = n;
      cycle();
      ld_start = 1'b0;
   endtask

   task automatic rd_const(input string tag, input logic [63:0] a, input logic [79:0] exp);
      rd_addr = a;
      #1;
      check(tag, rd_instr, exp);
   endtask

   task automatic load_rand(input logic [7:0] b, input logic [8:0] n);
      start(b, n);
      s_valid = 1'b1;
      for (int k = 0; k < n; k++) begin
         s_data = 8'($urandom);
         cycle();
      end
      s_valid = 1'b0;
   endtask

   initial begin
      int k;
      // 1: reset
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      rd_addr = 64'd0;
      cycle();
      check("s1_instr", rd_instr, 80'h0);
      check("s1_rderr", 80'(rd_mem_error), 80'd0);
      check("s1_hold", 80'(cpu_hold), 80'd0);
      check("s1_done", 80'(ld_done), 80'd0);
      check("s1_ready", 80'(s_ready), 80'd0);

      // 2: straight load of the reference program
      start(8'd128, 9'd20);
      check("s2_hold_start", 80'(cpu_hold), 80'd1);
      s_valid = 1'b1;
      for (int j = 0; j < 20; j++) begin
         s_data = prog[j];
         cycle();
      end
      s_valid = 1'b0;
      check("s2_done", 80'(ld_done), 80'd1);
      check("s2_count", 80'(ld_count), 80'd20);
      check("s2_csum", 80'(ld_csum), 80'h4F);
      check("s2_ready", 80'(s_ready), 80'd0);
      rd_const("s2_win128", 64'd128, 80'h30F2000000000000000A);
      rd_const("s2_win138", 64'd138, 80'h30F00000000000000003);

      // 3: gapped stream with a mid-load start that must be ignored
      rst = 1'b1; cycle(); rst = 1'b0;
      start(8'd128, 9'd20);
      k = 0;
      for (int c = 0; c < 60 && k < 20; c++) begin
         s_valid = (c % 2 == 0);
         s_data  = s_valid ? prog[k] : 8'hEE;
         if (c == 9) begin ld_start = 1'b1; ld_base = 8'd0; ld_len = 9'd5; end
         else ld_start = 1'b0;
         cycle();
         if (s_valid) k++;
      end
      s_valid = 1'b0; ld_start = 1'b0;
      check("s3_count", 80'(ld_count), 80'd20);
      check("s3_done", 80'(ld_done), 80'd1);
      rd_const("s3_win0", 64'd0, 80'h0);
      rd_const("s3_win128", 64'd128, 80'h30F2000000000000000A);
      rd_const("s3_win138", 64'd138, 80'h30F00000000000000003);

      // 4: rejected loads leave memory intact
      load_rand(8'd240, 9'd16);
      rd_addr = 64'd246;
      start(8'd250, 9'd10);
      check("s4_err", 80'(ld_err), 80'd1);
      check("s4_ready", 80'(s_ready), 80'd0);
      check("s4_hold", 80'(cpu_hold), 80'd0);
      start(8'd5, 9'd0);
      check("s4_err_len0", 80'(ld_err), 80'd1);
      load_rand(8'd0, 9'd256);
      check("s4_full_done", 80'(ld_done), 80'd1);

      // 5: reset in the middle of a load
      rst = 1'b1; cycle(); rst = 1'b0;
      start(8'd128, 9'd20);
      s_valid = 1'b1;
      for (int j = 0; j < 5; j++) begin s_data = prog[j] | 8'h01; cycle(); end
      rst = 1'b1; cycle(); rst = 1'b0;
      check("s5_count", 80'(ld_count), 80'd0);
      check("s5_hold", 80'(cpu_hold), 80'd0);
      s_valid = 1'b0;
      cycle();
      rd_const("s5_win128", 64'd128, 80'h0);

      // 6: read window at the top of memory
      load_rand(8'd236, 9'd20);
      rd_addr = 64'd246; #1;
      check("s6_err246", 80'(rd_mem_error), 80'd0);
      rd_addr = 64'd247; #1;
      check("s6_err247", 80'(rd_mem_error), 80'd1);
      check("s6_last247", 80'(rd_instr[7:0]), 80'h0);
      rd_const("s6_huge", 64'h1_0000_0000, 80'h0);
      check("s6_errhuge", 80'(rd_mem_error), 80'd1);

      // randomized phase
      for (int c = 0; c < 1500; c++) begin
         rst      = ($urandom_range(0, 199) == 0);
         ld_start = ($urandom_range(0, 24) == 0);
         ld_base  = 8'($urandom);
         ld_len   = 9'($urandom_range(0, 300));
         if ($urandom_range(0, 1) == 0) ld_len = 9'($urandom_range(0, 40));
         s_valid  = ($urandom_range(0, 3) != 0);
         s_data   = 8'($urandom);
         case ($urandom_range(0, 3))
            0: rd_addr = 64'($urandom_range(0, 255));
            1: rd_addr = 64'($urandom_range(240, 260));
            2: rd_addr = {32'($urandom), 32'($urandom)};
            default: rd_addr = 64'(m_base);
         endcase
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
